// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: per-lane RV32I (+optional M) decode with one-deep output register.
// Define ALU_ISSUE_MEXT_EN to decode mul/div and enable the divider occupancy counter.
module alu_issue_ctrl #(
   parameter int unsigned LANES   = 2,
   parameter int unsigned DIV_LAT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES-1:0]     in_lane_vld,
   input  logic [7*LANES-1:0]   in_opcode,
   input  logic [3*LANES-1:0]   in_funct3,
   input  logic [7*LANES-1:0]   in_funct7,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES-1:0]     out_lane_vld,
   output logic [5*LANES-1:0]   out_aluop,
   output logic [2*LANES-1:0]   out_in1_sel,
   output logic [2*LANES-1:0]   out_in2_sel,
   output logic [LANES-1:0]     out_illegal,
   output logic                 div_busy
);

   localparam int unsigned NDIV_W = $clog2(LANES + 1);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_SLL    = 5'b00010;
   localparam logic [4:0] OP_XOR    = 5'b00011;
   localparam logic [4:0] OP_SRA    = 5'b00100;
   localparam logic [4:0] OP_SRL    = 5'b00101;
   localparam logic [4:0] OP_OR     = 5'b00110;
   localparam logic [4:0] OP_AND    = 5'b00111;
   localparam logic [4:0] OP_SLT    = 5'b01000;
   localparam logic [4:0] OP_SLTU   = 5'b01001;
`ifdef ALU_ISSUE_MEXT_EN
   localparam logic [4:0] OP_MUL    = 5'b10110;
   localparam logic [4:0] OP_MULH   = 5'b10010;
   localparam logic [4:0] OP_MULHSU = 5'b10001;
   localparam logic [4:0] OP_MULHU  = 5'b10000;
   localparam logic [4:0] OP_DIV    = 5'b11000;
   localparam logic [4:0] OP_DIVU   = 5'b11010;
   localparam logic [4:0] OP_REM    = 5'b11100;
   localparam logic [4:0] OP_REMU   = 5'b11110;
`endif

   localparam logic [1:0] SEL1_RS1  = 2'b00;
   localparam logic [1:0] SEL1_PC   = 2'b01;
   localparam logic [1:0] SEL1_ZERO = 2'b10;
   localparam logic [1:0] SEL2_RS2  = 2'b00;
   localparam logic [1:0] SEL2_SHMT = 2'b01;
   localparam logic [1:0] SEL2_I12  = 2'b10;
   localparam logic [1:0] SEL2_I20  = 2'b11;

   // base register-register / register-immediate op by funct3
   function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt_shift);
      logic [4:0] r;
      r = OP_ADD;
      case (f3)
         3'b000: r = OP_ADD;
         3'b001: r = OP_SLL;
         3'b010: r = OP_SLT;
         3'b011: r = OP_SLTU;
         3'b100: r = OP_XOR;
         3'b101: r = alt_shift ? OP_SRA : OP_SRL;
         3'b110: r = OP_OR;
         3'b111: r = OP_AND;
         default: r = OP_ADD;
      endcase
      return r;
   endfunction

   logic [5*LANES-1:0]  aluop_c;
   logic [2*LANES-1:0]  in1_sel_c;
   logic [2*LANES-1:0]  in2_sel_c;
   logic [LANES-1:0]    illegal_c;
   logic [NDIV_W-1:0]   ndiv_c;
   logic                accept_c;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] lane_op;
   logic [1:0] lane_s1;
   logic [1:0] lane_s2;
   logic       lane_ill;
   logic       lane_div;

   // per-lane decode; invalid lanes and illegal lanes both collapse to add/rs1/rs2
   always_comb begin
      aluop_c   = '0;
      in1_sel_c = '0;
      in2_sel_c = '0;
      illegal_c = '0;
      ndiv_c    = '0;
      opc       = '0;
      f3        = '0;
      f7        = '0;
      lane_op   = OP_ADD;
      lane_s1   = SEL1_RS1;
      lane_s2   = SEL2_RS2;
      lane_ill  = 1'b0;
      lane_div  = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         opc      = in_opcode[7*i +: 7];
         f3       = in_funct3[3*i +: 3];
         f7       = in_funct7[7*i +: 7];
         lane_op  = OP_ADD;
         lane_s1  = SEL1_RS1;
         lane_s2  = SEL2_RS2;
         lane_ill = 1'b0;
         lane_div = 1'b0;
         if (in_lane_vld[i]) begin
            case (opc)
               OPC_OP: begin
                  case (f7)
                     F7_BASE: lane_op = base_op(f3, 1'b0);
                     F7_ALT: begin
                        if (f3 == 3'b000)      lane_op = OP_SUB;
                        else if (f3 == 3'b101) lane_op = OP_SRA;
                        else                   lane_ill = 1'b1;
                     end
                     F7_MEXT: begin
`ifdef ALU_ISSUE_MEXT_EN
                        case (f3)
                           3'b000: lane_op = OP_MUL;
                           3'b001: lane_op = OP_MULH;
                           3'b010: lane_op = OP_MULHSU;
                           3'b011: lane_op = OP_MULHU;
                           3'b100: lane_op = OP_DIV;
                           3'b101: lane_op = OP_DIVU;
                           3'b110: lane_op = OP_REM;
                           3'b111: lane_op = OP_REMU;
                           default: lane_op = OP_ADD;
                        endcase
                        lane_div = f3[2];
`else
                        lane_ill = 1'b1;
`endif
                     end
                     default: lane_ill = 1'b1;
                  endcase
               end
               OPC_OP_IMM: begin
                  // addi has no sub form; only shifts look at funct7
                  lane_op = base_op(f3, f7 == F7_ALT);
                  lane_s2 = (f3 == 3'b001 || f3 == 3'b101) ? SEL2_SHMT : SEL2_I12;
               end
               OPC_LUI: begin
                  lane_s1 = SEL1_ZERO;
                  lane_s2 = SEL2_I20;
               end
               OPC_AUIPC: begin
                  lane_s1 = SEL1_PC;
                  lane_s2 = SEL2_I20;
               end
               default: lane_ill = 1'b1;
            endcase
         end
         if (lane_ill) begin
            lane_op  = OP_ADD;
            lane_s1  = SEL1_RS1;
            lane_s2  = SEL2_RS2;
            lane_div = 1'b0;
         end
         aluop_c[5*i +: 5]   = lane_op;
         in1_sel_c[2*i +: 2] = lane_s1;
         in2_sel_c[2*i +: 2] = lane_s2;
         illegal_c[i]        = lane_ill;
         ndiv_c              = ndiv_c + NDIV_W'(lane_div);
      end
   end

   logic                valid_q, valid_d;
   logic [LANES-1:0]    lane_vld_q, lane_vld_d;
   logic [5*LANES-1:0]  aluop_q, aluop_d;
   logic [2*LANES-1:0]  in1_sel_q, in1_sel_d;
   logic [2*LANES-1:0]  in2_sel_q, in2_sel_d;
   logic [LANES-1:0]    illegal_q, illegal_d;
   logic                div_busy_q;

   assign in_ready = (~valid_q | out_ready) & ~((ndiv_c != '0) & div_busy_q);
   assign accept_c = in_valid & in_ready;

   // output register: load on accept, drop valid on drain, otherwise hold
   always_comb begin
      valid_d    = valid_q;
      lane_vld_d = lane_vld_q;
      aluop_d    = aluop_q;
      in1_sel_d  = in1_sel_q;
      in2_sel_d  = in2_sel_q;
      illegal_d  = illegal_q;
      if (accept_c) begin
         valid_d    = 1'b1;
         lane_vld_d = in_lane_vld;
         aluop_d    = aluop_c;
         in1_sel_d  = in1_sel_c;
         in2_sel_d  = in2_sel_c;
         illegal_d  = illegal_c;
      end else if (out_ready) begin
         valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         lane_vld_q <= '0;
         aluop_q    <= '0;
         in1_sel_q  <= '0;
         in2_sel_q  <= '0;
         illegal_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         lane_vld_q <= lane_vld_d;
         aluop_q    <= aluop_d;
         in1_sel_q  <= in1_sel_d;
         in2_sel_q  <= in2_sel_d;
         illegal_q  <= illegal_d;
      end
   end

`ifdef ALU_ISSUE_MEXT_EN
   localparam int unsigned CNT_W = $clog2(DIV_LAT * LANES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_busy_d;

   // divider occupancy: reload per accepted div bundle, else count down to zero
   always_comb begin
      cnt_d = cnt_q;
      if (accept_c && (ndiv_c != '0)) begin
         cnt_d = CNT_W'(DIV_LAT * ndiv_c);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      div_busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         div_busy_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_busy_q <= div_busy_d;
      end
   end
`else
   assign div_busy_q = 1'b0;
`endif

   assign out_valid    = valid_q;
   assign out_lane_vld = lane_vld_q;
   assign out_aluop    = aluop_q;
   assign out_in1_sel  = in1_sel_q;
   assign out_in2_sel  = in2_sel_q;
   assign out_illegal  = illegal_q;
   assign div_busy     = div_busy_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: transaction-level reference model plus directed pins.
// Honours ALU_ISSUE_MEXT_EN the same way the design does.
module tb_alu_issue_ctrl;

   localparam int L  = 2;
   localparam int DL = 8;
`ifdef ALU_ISSUE_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [L-1:0]      in_lane_vld;
   logic [7*L-1:0]    in_opcode;
   logic [3*L-1:0]    in_funct3;
   logic [7*L-1:0]    in_funct7;
   logic              out_valid;
   logic              out_ready;
   logic [L-1:0]      out_lane_vld;
   logic [5*L-1:0]    out_aluop;
   logic [2*L-1:0]    out_in1_sel;
   logic [2*L-1:0]    out_in2_sel;
   logic [L-1:0]      out_illegal;
   logic              div_busy;

   alu_issue_ctrl #(.LANES(L), .DIV_LAT(DL)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_vld(in_lane_vld), .in_opcode(in_opcode),
      .in_funct3(in_funct3), .in_funct7(in_funct7),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_vld(out_lane_vld), .out_aluop(out_aluop),
      .out_in1_sel(out_in1_sel), .out_in2_sel(out_in2_sel),
      .out_illegal(out_illegal), .div_busy(div_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       ill;
      logic       isdiv;
      logic [4:0] op;
      logic [1:0] s1;
      logic [1:0] s2;
   } dec_t;

   // funct3-indexed ALU code tables
   logic [4:0] base_tab [8] = '{5'b00000, 5'b00010, 5'b01000, 5'b01001,
                                5'b00011, 5'b00101, 5'b00110, 5'b00111};
   logic [4:0] m_tab    [8] = '{5'b10110, 5'b10010, 5'b10001, 5'b10000,
                                5'b11000, 5'b11010, 5'b11100, 5'b11110};

   int n_checks = 0;
   int n_fail   = 0;

   logic           m_valid;
   logic [L-1:0]   m_vld;
   logic [5*L-1:0] m_aluop;
   logic [2*L-1:0] m_in1;
   logic [2*L-1:0] m_in2;
   logic [L-1:0]   m_ill;
   int             m_cnt;
   bit             last_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic dec_t ref_dec(input logic v, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [6:0] f7);
      dec_t d;
      d = '0;
      if (!v) return d;
      if (op == 7'h33 && f7 == 7'h00) d.op = base_tab[f3];
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) d.op = 5'b00001;
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd5) d.op = 5'b00100;
      else if (op == 7'h33 && f7 == 7'h01 && MEXT) begin
         d.op    = m_tab[f3];
         d.isdiv = (f3 >= 3'd4);
      end else if (op == 7'h13) begin
         d.op = (f3 == 3'd5 && f7 == 7'h20) ? 5'b00100 : base_tab[f3];
         d.s2 = (f3 == 3'd1 || f3 == 3'd5) ? 2'b01 : 2'b10;
      end else if (op == 7'h37) begin
         d.s1 = 2'b10; d.s2 = 2'b11;
      end else if (op == 7'h17) begin
         d.s1 = 2'b01; d.s2 = 2'b11;
      end else d.ill = 1'b1;
      return d;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_vld = '0; m_aluop = '0; m_in1 = '0; m_in2 = '0; m_ill = '0;
      m_cnt = 0; last_acc = 1'b0;
   endtask

   // one clock: compare DUT with model mid-cycle, then advance model across the edge
   task automatic cycle();
      int nd;
      logic rdy;
      dec_t d;
      logic [5*L-1:0] na;
      logic [2*L-1:0] n1, n2;
      logic [L-1:0] ni;
      nd = 0; na = '0; n1 = '0; n2 = '0; ni = '0;
      @(negedge clk);
      for (int i = 0; i < L; i++) begin
         d = ref_dec(in_lane_vld[i], in_opcode[7*i +: 7], in_funct3[3*i +: 3], in_funct7[7*i +: 7]);
         nd += int'(d.isdiv);
         na[5*i +: 5] = d.op; n1[2*i +: 2] = d.s1; n2[2*i +: 2] = d.s2; ni[i] = d.ill;
      end
      rdy = (!m_valid || out_ready) && !(nd > 0 && m_cnt > 0);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("div_busy", 32'(div_busy), 32'(m_cnt > 0));
      if (m_valid) begin
         chk("lane_vld", 32'(out_lane_vld), 32'(m_vld));
         chk("aluop", 32'(out_aluop), 32'(m_aluop));
         chk("in1_sel", 32'(out_in1_sel), 32'(m_in1));
         chk("in2_sel", 32'(out_in2_sel), 32'(m_in2));
         chk("illegal", 32'(out_illegal), 32'(m_ill));
      end
      @(posedge clk);
      last_acc = in_valid && rdy;
      if (last_acc && nd > 0) m_cnt = DL * nd;
      else if (m_cnt > 0) m_cnt--;
      if (last_acc) begin
         m_valid = 1'b1; m_vld = in_lane_vld; m_aluop = na; m_in1 = n1; m_in2 = n2; m_ill = ni;
      end else if (out_ready) m_valid = 1'b0;
      #1;
   endtask

   task automatic set_lane(input int i, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      in_opcode[7*i +: 7] = op;
      in_funct3[3*i +: 3] = f3;
      in_funct7[7*i +: 7] = f7;
   endtask

   task automatic rand_lane(input int i);
      logic [6:0] op, f7;
      case ($urandom % 6)
         0, 1:    op = 7'h33;
         2:       op = 7'h13;
         3:       op = 7'h37;
         4:       op = 7'h17;
         default: op = 7'($urandom);
      endcase
      case ($urandom % 4)
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      set_lane(i, op, 3'($urandom), f7);
   endtask

   initial begin
      int st;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_lane_vld = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
      model_reset();
      #16;
      rst_n = 1'b1;

      // lane0 add, lane1 sub, accepted on the first edge after reset
      set_lane(0, 7'h33, 3'd0, 7'h00);
      set_lane(1, 7'h33, 3'd0, 7'h20);
      in_lane_vld = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      chk("addsub_valid", 32'(out_valid), 32'd1);
      chk("addsub_aluop", 32'(out_aluop), 32'h020);
      chk("addsub_in1", 32'(out_in1_sel), 32'd0);
      chk("addsub_in2", 32'(out_in2_sel), 32'd0);

      // lane0 srai, lane1 lui
      set_lane(0, 7'h13, 3'd5, 7'h20);
      set_lane(1, 7'h37, 3'd3, 7'h55);
      cycle();
      chk("srai_lui_aluop", 32'(out_aluop), 32'h004);
      chk("srai_lui_in2", 32'(out_in2_sel), 32'hD);
      chk("srai_lui_in1", 32'(out_in1_sel), 32'h8);

      // backpressure for three cycles, then replace on the draining edge
      set_lane(0, 7'h33, 3'd4, 7'h00);
      set_lane(1, 7'h33, 3'd7, 7'h00);
      out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      repeat (3) begin
         cycle();
         chk("stall_hold_aluop", 32'(out_aluop), 32'h004);
         chk("stall_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      cycle();
      chk("replace_aluop", 32'(out_aluop), 32'h0E3);
      in_valid = 1'b0;
      cycle();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // illegal opcode on lane1
      set_lane(0, 7'h33, 3'd0, 7'h00);
      set_lane(1, 7'h7F, 3'd0, 7'h00);
      in_valid = 1'b1;
      cycle();
      chk("illegal_flags", 32'(out_illegal), 32'h2);
      chk("illegal_aluop", 32'(out_aluop), 32'd0);

`ifdef ALU_ISSUE_MEXT_EN
      // two divs occupy the divider for 2*DL cycles; a second div bundle waits that long
      set_lane(0, 7'h33, 3'd4, 7'h01);
      set_lane(1, 7'h33, 3'd4, 7'h01);
      cycle();
      chk("div_busy_set", 32'(div_busy), 32'd1);
      st = 0;
      while (!in_ready && st < 100) begin
         st++;
         cycle();
      end
      chk("div_stall_cycles", 32'(st), 32'd16);
      cycle();
      set_lane(0, 7'h33, 3'd0, 7'h00);
      set_lane(1, 7'h13, 3'd0, 7'h00);
      #1;
      chk("add_while_busy_ready", 32'(in_ready), 32'd1);
      cycle();
      chk("busy_after_add", 32'(div_busy), 32'd1);
      set_lane(0, 7'h33, 3'd6, 7'h01);
      cycle();
      chk("div_blocked", 32'(last_acc), 32'd0);
`else
      // mul/div are illegal and never occupy the divider
      set_lane(0, 7'h33, 3'd0, 7'h01);
      set_lane(1, 7'h33, 3'd4, 7'h01);
      cycle();
      chk("mul_illegal", 32'(out_illegal), 32'h3);
      chk("nomext_busy", 32'(div_busy), 32'd0);
      #1;
      chk("nomext_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      cycle();
      cycle();
`endif

      // asynchronous reset in the middle of a stall
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_div_busy", 32'(div_busy), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1;
      cycle();

      // randomized traffic; a stalled bundle is held until accepted
      for (int n = 0; n < 800; n++) begin
         if (!in_valid || last_acc) begin
            in_lane_vld = L'($urandom);
            for (int i = 0; i < L; i++) rand_lane(i);
            in_valid = ($urandom % 4) != 0;
         end
         out_ready = ($urandom % 10) < 7;
         cycle();
      end

      in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
